// File: rtl/sonic_ast_pkg.sv
// Shared types and the round-robin pick function for the Avalon-ST packet arbiter.
package sonic_ast_pkg;

    localparam int MAX_IN       = 8;
    localparam int IDX_MAX_W    = 3;
    localparam int IDX_CNT_W    = IDX_MAX_W + 1;
    localparam int BEAT_DATA_W  = 128;
    localparam int BEAT_EMPTY_W = 4;

    // state     | meaning
    // ST_IDLE   | no packet in flight; the round-robin winner may start one
    // ST_LOCKED | owner holds the output until its eop beat is accepted
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0]  data;
        logic                    sop;
        logic                    eop;
        logic [BEAT_EMPTY_W-1:0] empty;
    } beat_t;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic                 found;
    } rr_pick_t;

    // First set bit of req at or above ptr, wrapping at num_in. Inputs are
    // sized for the largest supported arbiter; callers zero-extend.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_IN-1:0]    req,
        input logic [IDX_MAX_W-1:0] ptr,
        input logic [IDX_CNT_W-1:0] num_in
    );
        rr_pick_t             res;
        logic [IDX_CNT_W-1:0] cand;
        res = '0;
        for (int k = 0; k < MAX_IN; k++) begin
            cand = {1'b0, ptr} + IDX_CNT_W'(k);
            if (cand >= num_in) begin
                cand = cand - num_in;
            end
            if (!res.found && (IDX_CNT_W'(k) < num_in) && req[cand[IDX_MAX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[IDX_MAX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sonic_ast_arbiter_if.sv
// Bundle of the per-source Avalon-ST inputs and the merged output stream.
interface sonic_ast_arbiter_if #(
    parameter int NUM_IN  = 2,
    parameter int DATA_W  = 128,
    parameter int EMPTY_W = 4,
    parameter int CH_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);

    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN-1:0]         in_ready;
    logic [NUM_IN*DATA_W-1:0]  in_data;
    logic [NUM_IN-1:0]         in_sop;
    logic [NUM_IN-1:0]         in_eop;
    logic [NUM_IN*EMPTY_W-1:0] in_empty;

    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic                      out_sop;
    logic                      out_eop;
    logic [EMPTY_W-1:0]        out_empty;
    logic [CH_W-1:0]           out_channel;

    logic                      busy;
    logic                      proto_err;

    // The arbiter side: sinks the sources, drives the merged stream.
    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_empty, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_empty,
        output out_channel, busy, proto_err
    );

    // The environment side: sources plus the downstream sink.
    modport master (
        output in_valid, in_data, in_sop, in_eop, in_empty, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_empty,
        input  out_channel, busy, proto_err
    );

endinterface

// File: rtl/sonic_rr_picker.sv
// Combinational round-robin picker: lowest requesting index at or after ptr.
module sonic_rr_picker
    import sonic_ast_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  grant,
    output logic              found
);

    logic [MAX_IN-1:0]    req_ext;
    logic [IDX_MAX_W-1:0] ptr_ext;
    rr_pick_t             pick;

    // Widen to the package's fixed sizes, pick, then narrow back; an index that
    // does not fit IDX_W can only come from a bad ptr and never grants.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_IN-1:0]  = req;
        ptr_ext              = '0;
        ptr_ext[IDX_W-1:0]   = ptr;
        pick                 = rr_pick(req_ext, ptr_ext, IDX_CNT_W'(NUM_IN));
        grant                = pick.idx[IDX_W-1:0];
        found                = pick.found && ((pick.idx >> IDX_W) == '0);
    end

endmodule

// File: rtl/sonic_ast_arbiter.sv
// Packet-locked round-robin merge of NUM_IN Avalon-ST sources into one
// registered output stream tagged with the source index.
module sonic_ast_arbiter
    import sonic_ast_pkg::*;
#(
    parameter int NUM_IN  = 2,
    parameter int DATA_W  = 128,
    parameter int EMPTY_W = 4,
    parameter int CH_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic clk,
    input  logic reset,
    sonic_ast_arbiter_if.slave bus
);

    // The output register is built from the package beat type, so the data
    // path widths are tied to it.
    if (DATA_W != BEAT_DATA_W || EMPTY_W != BEAT_EMPTY_W || NUM_IN < 2 || NUM_IN > MAX_IN) begin : g_param_check
        $error("sonic_ast_arbiter: unsupported parameter set");
    end

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   owner_q, owner_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              proto_err_q, proto_err_d;
    logic              out_valid_q, out_valid_d;
    beat_t             out_beat_q, out_beat_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;

    logic              load;
    logic              xfer;
    logic [CH_W-1:0]   win_idx;
    logic              win_found;
    logic [CH_W-1:0]   sel;
    logic [NUM_IN-1:0] in_ready_c;
    beat_t             sel_beat;

    function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] idx);
        return (idx == CH_W'(NUM_IN - 1)) ? '0 : idx + 1'b1;
    endfunction

    sonic_rr_picker #(
        .NUM_IN (NUM_IN),
        .IDX_W  (CH_W)
    ) u_picker (
        .req   (bus.in_valid),
        .ptr   (rr_ptr_q),
        .grant (win_idx),
        .found (win_found)
    );

    // Grant and input mux: the owner while locked, the round-robin winner while idle.
    always_comb begin
        load       = !out_valid_q || bus.out_ready;
        sel        = (state_q == ST_LOCKED) ? owner_q : win_idx;
        in_ready_c = '0;
        sel_beat   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == CH_W'(i)) begin
                if (state_q == ST_LOCKED || win_found) begin
                    in_ready_c[i] = load;
                end
                sel_beat.data  = bus.in_data[i*DATA_W +: DATA_W];
                sel_beat.sop   = bus.in_sop[i];
                sel_beat.eop   = bus.in_eop[i];
                sel_beat.empty = bus.in_empty[i*EMPTY_W +: EMPTY_W];
            end
        end
        xfer = |(bus.in_valid & in_ready_c);
    end

    // Next state: lock on a multi-beat first beat; release and advance the pointer on eop.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        proto_err_d = proto_err_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (sel_beat.eop) begin
                        rr_ptr_d = wrap_inc(sel);
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = sel;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    // A second sop inside a locked packet is flagged but still forwarded.
                    if (sel_beat.sop) begin
                        proto_err_d = 1'b1;
                    end
                    if (sel_beat.eop) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = wrap_inc(sel);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage: refill whenever empty or draining; valid tracks the input transfer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        out_ch_d    = out_ch_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_beat_d = sel_beat;
                out_ch_d   = sel;
            end
        end
    end

    // State and output registers; reset truncates any packet in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_beat_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            proto_err_q <= proto_err_d;
            out_valid_q <= out_valid_d;
            out_beat_q  <= out_beat_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_beat_q.data;
    assign bus.out_sop     = out_beat_q.sop;
    assign bus.out_eop     = out_beat_q.eop;
    assign bus.out_empty   = out_beat_q.empty;
    assign bus.out_channel = out_ch_q;
    assign bus.busy        = (state_q == ST_LOCKED);
    assign bus.proto_err   = proto_err_q;

endmodule
